// File: rtl/debounce_sched.sv
// Round-robin debounce scheduler: one shared settle counter qualifies KEYS raw inputs in turn.
// Define DEBOUNCE_SYNC_EN to insert a 2-flop synchronizer ahead of the sampled key vector.
module debounce_sched #(
    parameter int KEYS  = 4,
    parameter int END   = 15,
    parameter int WIDTH = 4,
    localparam int IW   = (KEYS > 1) ? $clog2(KEYS) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [KEYS-1:0] key_raw,
    output logic [KEYS-1:0] key_level,
    output logic [KEYS-1:0] key_press,
    output logic [KEYS-1:0] key_release,
    output logic            busy,
    output logic [IW-1:0]   cur_key
);

    typedef enum logic {IDLE, SETTLE} state_t;

    state_t           state_q, state_d;
    logic [KEYS-1:0]  level_q, level_d;
    logic [KEYS-1:0]  press_q, press_d;
    logic [KEYS-1:0]  release_q, release_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [IW-1:0]    ptr_q, ptr_d;
    logic [IW-1:0]    sel_q, sel_d;

    logic [KEYS-1:0]  s;
    logic [KEYS-1:0]  mism;
    logic             found;
    logic [IW-1:0]    found_idx;
    logic [IW-1:0]    sel_next;
    logic             sel_mism;
    logic             at_end;

`ifdef DEBOUNCE_SYNC_EN
    logic [KEYS-1:0] sync1_q, sync2_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= key_raw;
            sync2_q <= sync1_q;
        end
    end

    assign s = sync2_q;
`else
    assign s = key_raw;
`endif

    assign mism     = s ^ level_q;
    assign sel_mism = mism[sel_q];
    assign at_end   = (cnt_q == WIDTH'(END));
    assign sel_next = (sel_q == IW'(KEYS - 1)) ? '0 : sel_q + 1'b1;

    // First mismatched key in rotated order ptr, ptr+1, ... (mod KEYS)
    always_comb begin
        logic [IW-1:0] idx;
        found     = 1'b0;
        found_idx = ptr_q;
        idx       = '0;
        for (int unsigned i = 0; i < KEYS; i++) begin
            idx = IW'((32'(ptr_q) + i) % KEYS);
            if (!found && mism[idx]) begin
                found     = 1'b1;
                found_idx = idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (found) state_d = SETTLE;
            SETTLE:  if (!sel_mism || at_end) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        level_d   = level_q;
        press_d   = '0;
        release_d = '0;
        cnt_d     = cnt_q;
        ptr_d     = ptr_q;
        sel_d     = sel_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    sel_d = found_idx;
                    cnt_d = '0;
                end
            end
            SETTLE: begin
                if (!sel_mism) begin
                    ptr_d = sel_next;
                end else if (at_end) begin
                    level_d[sel_q] = ~level_q[sel_q];
                    if (level_q[sel_q]) release_d[sel_q] = 1'b1;
                    else                press_d[sel_q]   = 1'b1;
                    ptr_d = sel_next;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            level_q   <= '0;
            press_q   <= '0;
            release_q <= '0;
            cnt_q     <= '0;
            ptr_q     <= '0;
            sel_q     <= '0;
        end else begin
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            cnt_q     <= cnt_d;
            ptr_q     <= ptr_d;
            sel_q     <= sel_d;
        end
    end

    always_comb begin
        busy        = (state_q == SETTLE);
        cur_key     = sel_q;
        key_level   = level_q;
        key_press   = press_q;
        key_release = release_q;
    end

endmodule

// File: doc/debounce_sched.md
# debounce_sched

Round-robin debounce scheduler that time-shares one settle counter among `KEYS` raw push-button inputs. It sits between the board button pins and the user logic. It produces a per-key debounced level plus one-cycle press and release pulses. Only one key is qualified at a time, so the counter cost stays constant regardless of key count.

## Interface
Parameters:
- `KEYS`, 4: number of raw key inputs, 2..16.
- `END`, 15: settle count. Must satisfy `END < 2**WIDTH` and `END >= 1`.
- `WIDTH`, 4: settle counter width.

Ports:
- `clk`  in  1  system clock. All logic is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `key_raw`  in  KEYS  raw, asynchronous, active-high key pins.
- `key_level`  out  KEYS  debounced key state (registered).
- `key_press`  out  KEYS  one-cycle pulse when `key_level[k]` commits 0->1.
- `key_release`  out  KEYS  one-cycle pulse when `key_level[k]` commits 1->0.
- `busy`  out  1  high while a key is being qualified (state SETTLE).
- `cur_key`  out  max(1,$clog2(KEYS))  index of the key under qualification. Valid only while `busy` is high.

## Operation
- The sampled vector `s` is `key_raw` after the optional synchronizer (see Configuration).
- A key is mismatched when `s[k] != key_level[k]`.
- Internal state:
  - FSM with states IDLE and SETTLE.
  - Round-robin pointer `ptr`.
  - Settle counter `cnt` of `WIDTH` bits.
  - Selected index `sel`, which drives `cur_key`.
- IDLE behaviour:
  - Search order is `ptr, ptr+1, … ptr+KEYS-1`, each index taken mod `KEYS`.
  - On the first mismatched key found: `sel <= k`, `cnt <= 0`, go to SETTLE.
  - If no key is mismatched, stay in IDLE.
- SETTLE behaviour, evaluated at each edge on key `sel` only:
  - Abort: if the mismatch is gone, go to IDLE, `ptr <= (sel+1) mod KEYS`, and `key_level` is unchanged.
  - Commit: if the mismatch persists and `cnt == END`, toggle `key_level[sel]`.
    - Assert `key_press[sel]` if the new level is 1, otherwise `key_release[sel]`.
    - The pulse is high for exactly one cycle.
    - Go to IDLE with `ptr <= (sel+1) mod KEYS`.
  - Otherwise `cnt <= cnt + 1`.
- Mismatches on keys other than `sel` are ignored while in SETTLE. They are picked up on the next IDLE search.
- Rotating the pointer after both commit and abort prevents a chattering low-index key from starving the others.
- Counter arithmetic:
  - `cnt` never exceeds `END`, so it never wraps.
  - `cnt` is don't-care in IDLE and is cleared on each SETTLE entry.
- Reset:
  - `key_level`, `key_press`, `key_release`, `cnt`, `ptr`, `sel` and synchronizer flops all go to 0.
  - State goes to IDLE, `busy = 0`, `cur_key = 0`.
  - Reset asserted mid-SETTLE discards the qualification. No pulse is generated.

## Timing
- Selection edge E0: IDLE sees the mismatch, and `busy` goes high after E0.
- Edges E1..E(END) increment `cnt` to END.
- Edge E(END+1) commits: `key_level` changes and the pulse appears in the cycle after E(END+1).
- `busy` goes low in that same cycle.
- Minimum qualification time is therefore END+1 cycles after selection.
- Earliest next selection is the edge after the commit or abort edge, so each key costs at least one IDLE cycle.
- An abort at edge Ej (1 ≤ j ≤ END+1) returns to IDLE after Ej.
- Worst-case wait for a key with all keys active is (KEYS-1)·(END+2) cycles.
- `key_press` and `key_release` are never high in the same cycle. At most one bit of each is set.

## Configuration
- `DEBOUNCE_SYNC_EN` defined:
  - `s` is `key_raw` passed through a 2-flop synchronizer per bit, reset to 0.
  - A raw change is first visible to IDLE 2 edges after it is set up.
- `DEBOUNCE_SYNC_EN` undefined:
  - `s = key_raw` directly, with no added latency.
  - The inputs must already be synchronous to `clk`.

## Test plan
Bench uses KEYS=4, END=3, `DEBOUNCE_SYNC_EN` undefined.
- Reset then idle: after `rst` is held 2 cycles with `key_raw=4'b0000`, every output is 0 and `busy=0` for 10 cycles.
- Clean press: `key_raw[2]` goes 0->1 and is held.
  - `busy=1` and `cur_key=2` for cycles 1..4 after the selection edge.
  - `key_level=4'b0100` follows, with `key_press=4'b0100` for exactly 1 cycle.
  - Releasing the key gives `key_release=4'b0100` after the same latency.
- Bounce abort: `key_raw[1]` goes high for 2 cycles, then low.
  - SETTLE aborts and `key_level` stays 0000 with no pulses.
  - `ptr` becomes 2, checked by then asserting keys 0 and 3 together: key 3 is served first.
- Simultaneous press: `key_raw=4'b1111` from `ptr=0`.
  - Commits occur in the order 0,1,2,3, 5 cycles apart.
  - Final `key_level=4'b1111`, with each `key_press` bit pulsed once.
- Reset mid-SETTLE: press key 0 and assert `rst` when `cnt=2`.
  - Next cycle: `busy=0`, `key_level=0`, no pulse.
  - After `rst` deasserts with key 0 still held, the key re-qualifies in a full END+1 cycles.
- With `DEBOUNCE_SYNC_EN` defined: the clean-press scenario shows a commit exactly 2 cycles later than without the macro.
